hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Multi-cycle divide sequencer and HI/LO register owner for the EX stage. Accepts a divide command from the pipeline and runs a 32-iteration restoring division. Writes the quotient to LO and the remainder to HI, and services mthi/mtlo writes. Raises a stall request while the pipeline touches HI/LO or issues another divide before the current one finishes.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  divide command from EX; accepted only in IDLE
- sign  in  1  1 = signed div, 0 = divu (sampled with start)
- a  in  32  dividend (sampled with start)
- b  in  32  divisor (sampled with start)
- flush  in  1  abort the in-flight op (exception/branch flush)
- hilo_we  in  1  mthi/mtlo write request
- hilo_sel  in  1  0 = HI, 1 = LO
- hilo_wdata  in  32  mthi/mtlo data
- rd_req  in  1  mfhi/mflo in EX needs HI/LO this cycle
- busy  out  1  high in RUN and FIX
- done  out  1  registered one-cycle pulse; new HI/LO visible this cycle
- stall  out  1  combinational: busy & (start | hilo_we | rd_req)
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE → RUN: start & ~flush & b≠0. Latch operands, counter = 0.
  - Signed mode: latch |a| and |b|, plus sign_q = a[31]^b[31] and sign_r = a[31].
- IDLE with start & ~flush & b==0: stay IDLE. Write hi = a and lo = 32'hFFFF_FFFF at that edge. Pulse done next cycle.
- RUN: each cycle, shift the 33-bit partial remainder left by one and bring in the next dividend bit. Trial-subtract the divisor. Shift in a quotient bit of 1 if the result is non-negative (keep the difference), else 0 (restore). The counter increments. After iteration 32 → FIX.
- FIX: in signed mode, negate the quotient if sign_q and negate the remainder if sign_r. Write lo = quotient and hi = remainder. Go to IDLE and pulse done.
- Width rules: all results mod 2^32. Signed 0x8000_0000 / 0xFFFF_FFFF gives lo = 0x8000_0000, hi = 0.
- hilo_we in IDLE: write hilo_wdata to the selected register at the edge.
- hilo_we while busy: not applied. stall holds it until IDLE.
- start and hilo_we in the same IDLE cycle: both accepted. The later divide result overwrites HI/LO.
- start while busy: ignored. stall keeps the pipeline holding it.
- flush in any state: next state IDLE, no done, HI/LO unchanged. Takes priority over start and hilo_we in the same cycle.
- rd_req in IDLE: no stall. hi/lo outputs are current, including on the done cycle.

## Timing
- start accepted at edge t (end of cycle t−1 sample). busy=1 in cycles t..t+32: RUN t..t+31, FIX t+32.
- done=1 and new HI/LO visible at cycle t+33, counted from the accepting edge. Latency is 34 cycles from start-asserted cycle to done.
- Divide-by-zero: done and HI/LO visible the cycle after start.
- stall is combinational, same cycle as the request. It drops in the first IDLE cycle, which is the done cycle.
- flush sampled in cycle c: busy=0 from cycle c+1.
- Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, stall=0. Counter and operand latches are cleared.
- rst mid-operation: same as the reset values. No done is emitted.

## Configuration
- DIV_SIGNED_EN defined: signed division supported as described, using sign, the abs-at-latch step and negate-in-FIX.
- DIV_SIGNED_EN undefined:
  - The sign input is ignored and every divide is unsigned.
  - FIX still occupies one cycle, so latency is identical in both builds.
  - Divide-by-zero behaviour is unchanged.

## Test plan
- Unsigned divide: a=100, b=7, sign=0. Expect busy for 33 cycles, then done with lo=14, hi=2. No done pulse at any other time.
- Signed divide, -7 / 2: a=0xFFFF_FFF9, b=2, sign=1.
  - With DIV_SIGNED_EN: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - Without DIV_SIGNED_EN: lo=0x7FFF_FFFC, hi=1.
- Divide-by-zero: a=0x1234, b=0. Expect done the next cycle with hi=0x1234, lo=0xFFFF_FFFF, and busy never asserted.
- Hazards while busy: assert rd_req and hilo_we (sel=0, data=5) during RUN. Expect stall=1 every busy cycle and HI not written. Hold the request into the done cycle: expect stall=0 and hi=5 on the following cycle.
- Flush at RUN cycle 10 after a prior result lo=14, hi=2. Expect busy=0 next cycle, no done, and lo=14, hi=2 retained.
- Mid-run reset: assert rst in the middle of RUN. Expect hi=lo=0 and busy=done=stall=0 next cycle. A new start then completes normally 34 cycles later.

Source files
------------

// File: rtl/hilo_div_ctrl_if.sv
// Pipeline-side bundle for the divide sequencer / HI-LO owner.
// The master side is the EX stage; the slave side is hilo_div_ctrl.
interface hilo_div_ctrl_if;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic        rd_req;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, sign, a, b, flush, hilo_we, hilo_sel, hilo_wdata, rd_req,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, sign, a, b, flush, hilo_we, hilo_sel, hilo_wdata, rd_req,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// 32-iteration restoring divider that owns HI/LO and raises EX stalls.
// Define DIV_SIGNED_EN to support signed division; otherwise every divide is unsigned.
module hilo_div_ctrl (
  input  logic            clk,
  input  logic            rst,
  hilo_div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_div0;
  logic        w_busy;
  logic [32:0] w_shift;
  logic        w_qbit;
  logic [31:0] w_rem_n;
  logic [31:0] w_dvd_in;
  logic [31:0] w_dvs_in;
  logic        w_sign_q_in;
  logic        w_sign_r_in;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

`ifdef DIV_SIGNED_EN
  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    logic [31:0] r;
    r = v[31] ? -v : v;
    return r;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    logic signed [31:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  assign w_dvd_in    = bus.sign ? abs32(bus.a) : bus.a;
  assign w_dvs_in    = bus.sign ? abs32(bus.b) : bus.b;
  assign w_sign_q_in = bus.sign & (bus.a[31] ^ bus.b[31]);
  assign w_sign_r_in = bus.sign & bus.a[31];
  assign w_quo_fix   = neg_if(r_quo, r_sign_q);
  assign w_rem_fix   = neg_if(r_rem, r_sign_r);
`else
  logic w_unused_sign;
  assign w_unused_sign = &{1'b0, bus.sign, r_sign_q, r_sign_r};
  assign w_dvd_in      = bus.a;
  assign w_dvs_in      = bus.b;
  assign w_sign_q_in   = 1'b0;
  assign w_sign_r_in   = 1'b0;
  assign w_quo_fix     = r_quo;
  assign w_rem_fix     = r_rem;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  assign w_shift = {r_rem, r_dvd[31]};
  assign w_qbit  = (w_shift >= {1'b0, r_dvs});
  assign w_rem_n = w_qbit ? 32'(w_shift - {1'b0, r_dvs}) : w_shift[31:0];

  assign w_busy    = (r_state != S_IDLE);
  assign bus.busy  = w_busy;
  assign bus.stall = w_busy & (bus.start | bus.hilo_we | bus.rd_req);
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_div0    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (bus.b == 32'd0) begin
            w_div0 = 1'b1;
          end else begin
            w_accept  = 1'b1;
            w_state_n = S_RUN;
          end
        end
      end
      S_RUN:   if (r_cnt == 5'd31) w_state_n = S_FIX;
      S_FIX:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (bus.flush) w_state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_state <= w_state_n;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_dvd    <= w_dvd_in;
        r_dvs    <= w_dvs_in;
        r_sign_q <= w_sign_q_in;
        r_sign_r <= w_sign_r_in;
        r_quo    <= 32'd0;
        r_rem    <= 32'd0;
        r_cnt    <= 5'd0;
      end else if (r_state == S_RUN) begin
        r_rem <= w_rem_n;
        r_quo <= {r_quo[30:0], w_qbit};
        r_dvd <= {r_dvd[30:0], 1'b0};
        r_cnt <= 5'(r_cnt + 5'd1);
      end
      // mthi/mtlo first so a same-edge divide-by-zero result takes precedence
      if (r_state == S_IDLE && !bus.flush && bus.hilo_we) begin
        if (bus.hilo_sel) r_lo <= bus.hilo_wdata;
        else              r_hi <= bus.hilo_wdata;
      end
      if (w_div0) begin
        r_hi   <= bus.a;
        r_lo   <= 32'hFFFF_FFFF;
        r_done <= 1'b1;
      end
      if (r_state == S_FIX && !bus.flush) begin
        r_lo   <= w_quo_fix;
        r_hi   <= w_rem_fix;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Scoreboard bench for hilo_div_ctrl: stimulus pushes expected results, a monitor checks each done.
// Signed expectations follow DIV_SIGNED_EN when it is defined.
module tb_hilo_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vec = 0;
  int   err = 0;

  hilo_div_ctrl_if bus ();

  hilo_div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain-arithmetic quotient/remainder with divide-by-zero rule
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end
`ifdef DIV_SIGNED_EN
    else if (s) begin
      q = 32'(sa / sb_);
      r = 32'(sa % sb_);
    end
`endif
    else begin
      q = a / b;
      r = a % b;
      if (s && sa == 0 && sb_ == 0) q = 32'd0;
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard, on time
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        check("done_missing", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.due));
          check("done_lo", bus.lo, e.lo);
          check("done_hi", bus.hi, e.hi);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start cycle; returns in the cycle after the accepting edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit push, input bit with_we);
    logic [31:0] q, r;
    exp_t e;
    bus.start = 1'b1;
    bus.sign  = s;
    bus.a     = a;
    bus.b     = b;
    if (with_we) begin
      bus.hilo_we    = 1'b1;
      bus.hilo_sel   = 1'($urandom_range(0, 1));
      bus.hilo_wdata = $urandom;
      if (b != 32'd0) begin
        if (bus.hilo_sel) m_lo = bus.hilo_wdata;
        else              m_hi = bus.hilo_wdata;
      end
    end
    if (push) begin
      model(a, b, s, q, r);
      e.hi  = r;
      e.lo  = q;
      e.due = cyc + ((b == 32'd0) ? 1 : 34);
      sb.push_back(e);
      m_hi = r;
      m_lo = q;
    end
    tick();
    bus.start   = 1'b0;
    bus.hilo_we = 1'b0;
  endtask

  task automatic finish_op(input int exp_busy);
    int nb;
    nb = bus.busy ? 1 : 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      nb += bus.busy ? 1 : 0;
    end
    check("busy_cycles", 32'(nb), 32'(exp_busy));
    check("hi_after", bus.hi, m_hi);
    check("lo_after", bus.lo, m_lo);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input bit with_we);
    start_op(a, b, s, 1'b1, with_we);
    finish_op((b == 32'd0) ? 0 : 33);
  endtask

  task automatic write_hilo(input logic sel, input logic [31:0] d);
    bus.hilo_we    = 1'b1;
    bus.hilo_sel   = sel;
    bus.hilo_wdata = d;
    tick();
    bus.hilo_we = 1'b0;
    if (sel) m_lo = d;
    else     m_hi = d;
    check(sel ? "mtlo" : "mthi", sel ? bus.lo : bus.hi, d);
    check("mt_stall", 32'(bus.stall), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.sign = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
    bus.hilo_we = 0; bus.hilo_sel = 0; bus.hilo_wdata = 0; bus.rd_req = 0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);

    // Directed divides
    do_div(32'd100, 32'd7, 1'b0, 1'b0);
    check("u100_7_lo", bus.lo, 32'd14);
    check("u100_7_hi", bus.hi, 32'd2);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
`ifdef DIV_SIGNED_EN
    check("s_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
    check("s_m7_2_hi", bus.hi, 32'hFFFF_FFFF);
`else
    check("s_m7_2_lo", bus.lo, 32'h7FFF_FFFC);
    check("s_m7_2_hi", bus.hi, 32'd1);
`endif
    do_div(32'h0000_1234, 32'd0, 1'b0, 1'b0);
    check("dz_hi", bus.hi, 32'h1234);
    check("dz_lo", bus.lo, 32'hFFFF_FFFF);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef DIV_SIGNED_EN
    check("ovf_lo", bus.lo, 32'h8000_0000);
    check("ovf_hi", bus.hi, 32'd0);
`endif

    // Flush mid-run after a known result
    do_div(32'd100, 32'd7, 1'b0, 1'b0);
    start_op(32'd5000, 32'd3, 1'b0, 1'b0, 1'b0);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    repeat (40) tick();
    check("flush_lo", bus.lo, 32'd14);
    check("flush_hi", bus.hi, 32'd2);

    // Hazards while busy: stall every busy cycle, HI untouched until IDLE
    start_op(32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    bus.rd_req = 1'b1; bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'd5;
    begin
      bit seen_done = 0;
      for (int i = 0; i < 40 && !seen_done; i++) begin
        @(negedge clk);
        if (bus.busy) begin
          check("haz_stall", 32'(bus.stall), 32'd1);
          check("haz_hi_hold", bus.hi, 32'd2);
        end else if (bus.done) begin
          check("haz_stall_done", 32'(bus.stall), 32'd0);
          seen_done = 1;
        end
        tick();
      end
      if (!seen_done) check("haz_done_seen", 32'd0, 32'd1);
    end
    bus.rd_req = 1'b0; bus.hilo_we = 1'b0;
    m_hi = 32'd5;
    check("haz_hi", bus.hi, 32'd5);
    check("haz_lo", bus.lo, 32'd14);

    // Mid-run reset, then a normal divide
    start_op(32'd999, 32'd10, 1'b0, 1'b0, 1'b0);
    repeat (15) tick();
    rst = 1'b1;
    bus.rd_req = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("mrst_hi", bus.hi, 32'd0);
    check("mrst_lo", bus.lo, 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_stall", 32'(bus.stall), 32'd0);
    bus.rd_req = 1'b0;
    do_div(32'd1000, 32'd9, 1'b0, 1'b0);

    // Randomized divides and mthi/mtlo, including start+hilo_we in one cycle
    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra, rb;
      int mode;
      ra   = $urandom;
      mode = $urandom_range(0, 5);
      rb   = (mode == 0) ? 32'd0 : (mode < 3) ? 32'($urandom_range(1, 15)) : $urandom;
      if ($urandom_range(0, 3) == 0) write_hilo(1'($urandom_range(0, 1)), $urandom);
      do_div(ra, rb, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
